servo_pwm_array: RTL and testbench

Parametrised N-channel servo PWM generator with per-channel slew-rate limiting and glitch-free, frame-aligned duty updates. It replaces the fixed 4-channel servo driver between the gesture-to-angle mapping logic and the arm's servo pins. A single time-multiplexed sequencer computes each channel's ramped position and pulse width once per PWM frame. New pulse widths and enables take effect only at frame boundaries, so a pulse is never truncated or stretched.

---
 rtl/servo_pwm_array.sv | 131 +++++++++++++
 tb/tb_servo_pwm_array.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/servo_pwm_array.sv
// N-channel servo PWM generator: one time-multiplexed sequencer slews each channel
// once per frame; duty and enable commit only at the frame boundary.
module servo_pwm_array #(
  parameter int unsigned CLK_FREQ    = 100_000_000,
  parameter int unsigned PWM_FREQ    = 50,
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned ANGLE_W     = 8,
  parameter int unsigned PULSE_MIN   = 100_000,
  parameter int unsigned PULSE_MAX   = 200_000,
  parameter int unsigned STEP_MAX    = 4,
  parameter int unsigned RESET_ANGLE = 128
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_CH*ANGLE_W-1:0] angle,
  input  logic [NUM_CH-1:0]         angle_valid,
  input  logic [NUM_CH-1:0]         ch_enable,
  output logic [NUM_CH-1:0]         pwm,
  output logic                      frame_start,
  output logic [NUM_CH-1:0]         at_target
);

  localparam int unsigned PERIOD = CLK_FREQ / PWM_FREQ;
  localparam int unsigned CW     = $clog2(PERIOD);
  localparam int unsigned SCALE  = (PULSE_MAX - PULSE_MIN) / ((2 ** ANGLE_W) - 1);
  localparam int unsigned IW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [ANGLE_W-1:0] POS_RST  = ANGLE_W'(RESET_ANGLE);
  localparam logic [CW-1:0]      DUTY_RST = CW'(PULSE_MIN + RESET_ANGLE * SCALE);
  localparam logic [CW-1:0]      CNT_LAST = CW'(PERIOD - 1);
  localparam logic [IW-1:0]      IDX_LAST = IW'(NUM_CH - 1);

  typedef enum logic {S_IDLE, S_UPDATE} state_t;

  state_t             r_state;
  logic [IW-1:0]      r_idx;
  logic [CW-1:0]      r_cnt;
  logic [ANGLE_W-1:0] r_target   [NUM_CH];
  logic [ANGLE_W-1:0] r_pos      [NUM_CH];
  logic [CW-1:0]      r_shadow   [NUM_CH];
  logic [CW-1:0]      r_duty_act [NUM_CH];
  logic [NUM_CH-1:0]  r_en_act;

  logic [ANGLE_W-1:0] w_tgt;
  logic [ANGLE_W-1:0] w_pos;
  logic [ANGLE_W-1:0] w_mag;
  logic [ANGLE_W-1:0] w_new_pos;
  logic [CW-1:0]      w_duty;

  always_ff @(posedge clk) begin
    if (rst) r_cnt <= '0;
    else if (r_cnt == CNT_LAST) r_cnt <= '0;
    else r_cnt <= r_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < NUM_CH; k++) r_target[k] <= POS_RST;
    end else begin
      for (int unsigned k = 0; k < NUM_CH; k++)
        if (angle_valid[k]) r_target[k] <= angle[k*ANGLE_W +: ANGLE_W];
    end
  end

  // Slew step for the channel currently selected by the sequencer; never overshoots.
  always_comb begin
    w_tgt     = r_target[r_idx];
    w_pos     = r_pos[r_idx];
    w_mag     = (w_tgt >= w_pos) ? (w_tgt - w_pos) : (w_pos - w_tgt);
    w_new_pos = w_tgt;
    if (STEP_MAX != 0 && 32'(w_mag) > STEP_MAX) begin
      if (w_tgt > w_pos) w_new_pos = w_pos + ANGLE_W'(STEP_MAX);
      else               w_new_pos = w_pos - ANGLE_W'(STEP_MAX);
    end
    w_duty = CW'(PULSE_MIN + 32'(w_new_pos) * SCALE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        r_pos[k]    <= POS_RST;
        r_shadow[k] <= DUTY_RST;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_cnt == '0) begin
            r_state <= S_UPDATE;
            r_idx   <= '0;
          end
        end
        S_UPDATE: begin
          r_pos[r_idx]    <= w_new_pos;
          r_shadow[r_idx] <= w_duty;
          if (r_idx == IDX_LAST) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_en_act    <= '0;
      pwm         <= '0;
      frame_start <= 1'b0;
      for (int unsigned k = 0; k < NUM_CH; k++) r_duty_act[k] <= DUTY_RST;
    end else begin
      if (r_cnt == CNT_LAST) begin
        r_en_act <= ch_enable;
        for (int unsigned k = 0; k < NUM_CH; k++) r_duty_act[k] <= r_shadow[k];
      end
      for (int unsigned k = 0; k < NUM_CH; k++)
        pwm[k] <= r_en_act[k] && (r_cnt < r_duty_act[k]);
      frame_start <= (r_cnt == '0);
    end
  end

  always_comb begin
    at_target = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) at_target[k] = (r_pos[k] == r_target[k]);
  end

endmodule

// File: tb/tb_servo_pwm_array.sv
// Directed bench for servo_pwm_array: slew-limited (STEP_MAX=2) and unlimited (STEP_MAX=0)
// instances, with pulse widths measured per output frame against hand-computed values.
module tb_servo_pwm_array;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] angle = '0, angle0 = '0;
  logic [3:0]  valid = '0, valid0 = '0;
  logic [3:0]  ch_enable = 4'hF;
  logic [3:0]  pwm, pwm0, at_target, at_target0;
  logic        frame_start, frame_start0;

  int n_cmp = 0;
  int n_err = 0;
  int tb_cnt = 0;
  int g_w[4];
  int g_w0[4];
  int g_fs;
  logic g_fs_first;
  logic [3:0] g_ok;

  always #5 clk = ~clk;

  // Reference timebase: frame position of the design's counter in the current cycle.
  always @(posedge clk) begin
    if (rst) tb_cnt <= 0;
    else tb_cnt <= (tb_cnt == 99) ? 0 : tb_cnt + 1;
  end

  servo_pwm_array #(
    .CLK_FREQ(1000), .PWM_FREQ(10), .NUM_CH(4), .ANGLE_W(4),
    .PULSE_MIN(10), .PULSE_MAX(40), .STEP_MAX(2), .RESET_ANGLE(8)
  ) dut (
    .clk(clk), .rst(rst), .angle(angle), .angle_valid(valid), .ch_enable(ch_enable),
    .pwm(pwm), .frame_start(frame_start), .at_target(at_target)
  );

  servo_pwm_array #(
    .CLK_FREQ(1000), .PWM_FREQ(10), .NUM_CH(4), .ANGLE_W(4),
    .PULSE_MIN(10), .PULSE_MAX(40), .STEP_MAX(0), .RESET_ANGLE(8)
  ) dut0 (
    .clk(clk), .rst(rst), .angle(angle0), .angle_valid(valid0), .ch_enable(ch_enable),
    .pwm(pwm0), .frame_start(frame_start0), .at_target(at_target0)
  );

  task automatic wait_cnt(input int n);
    int guard = 0;
    while (tb_cnt != n && guard < 300) begin
      @(negedge clk);
      guard++;
    end
  endtask

  // One-cycle write strobe issued at the current negedge.
  task automatic wr(input bit sel0, input logic [3:0] mask, input logic [15:0] val);
    if (sel0) begin angle0 = val; valid0 = mask; end
    else begin angle = val; valid = mask; end
    @(negedge clk);
    valid = '0;
    valid0 = '0;
  endtask

  // Measures one output frame (counter 1..99 then 0); optionally changes ch_enable at sample act_i.
  task automatic meas(input int act_i, input logic [3:0] act_en);
    logic [3:0] prev;
    wait_cnt(1);
    prev = '0;
    g_ok = 4'hF;
    g_fs = 0;
    for (int k = 0; k < 4; k++) begin g_w[k] = 0; g_w0[k] = 0; end
    for (int i = 0; i < 100; i++) begin
      if (i == act_i) ch_enable = act_en;
      if (i == 0) g_fs_first = frame_start;
      if (frame_start) g_fs++;
      for (int k = 0; k < 4; k++) begin
        if (pwm[k]) begin
          g_w[k]++;
          if (!prev[k] && i != 0) g_ok[k] = 1'b0;
        end
        if (pwm0[k]) g_w0[k]++;
      end
      prev = pwm;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (pwm !== 4'h0 || frame_start !== 1'b0) begin
      n_err++; $display("FAIL rst_outputs: pwm=%h fs=%b, required pwm=0 fs=0", pwm, frame_start);
    end
    n_cmp++;
    if (at_target !== 4'hF || at_target0 !== 4'hF) begin
      n_err++; $display("FAIL rst_at_target: %h/%h, required F/F", at_target, at_target0);
    end
    rst = 1'b0;
    meas(-1, 4'hF);
    n_cmp++;
    if (pwm === 4'hx || g_w[0] + g_w[1] + g_w[2] + g_w[3] != 0 || g_w0[0] + g_w0[1] + g_w0[2] + g_w0[3] != 0) begin
      n_err++; $display("FAIL frame0_low: widths %0d %0d %0d %0d, required all 0", g_w[0], g_w[1], g_w[2], g_w[3]);
    end
    n_cmp++;
    if (g_fs != 1 || g_fs_first !== 1'b1) begin
      n_err++; $display("FAIL frame0_fs: count=%0d first=%b, required 1/1", g_fs, g_fs_first);
    end
    meas(-1, 4'hF);
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (g_w[k] != 26 || g_w0[k] != 26 || g_ok[k] !== 1'b1) begin
        n_err++; $display("FAIL frame1_width ch%0d: %0d/%0d contig=%b, required 26/26 contig=1", k, g_w[k], g_w0[k], g_ok[k]);
      end
    end
    n_cmp++;
    if (g_fs != 1 || g_fs_first !== 1'b1 || at_target !== 4'hF) begin
      n_err++; $display("FAIL frame1_fs: count=%0d first=%b at=%h, required 1/1/F", g_fs, g_fs_first, at_target);
    end
  endtask

  task automatic test_slew;
    int exp_w[6] = '{26, 30, 34, 38, 40, 40};
    logic [3:0] exp_at[6] = '{4'hE, 4'hE, 4'hE, 4'hF, 4'hF, 4'hF};
    wait_cnt(50);
    wr(1'b0, 4'b0001, 16'h000F);
    n_cmp++;
    if (at_target !== 4'hE) begin
      n_err++; $display("FAIL slew_at_write: at_target=%h, required E", at_target);
    end
    for (int f = 0; f < 6; f++) begin
      meas(-1, 4'hF);
      n_cmp++;
      if (g_w[0] != exp_w[f] || g_w[1] != 26 || g_w[2] != 26 || g_w[3] != 26 || g_ok !== 4'hF) begin
        n_err++; $display("FAIL slew_frame%0d: widths %0d %0d %0d %0d, required %0d 26 26 26", f, g_w[0], g_w[1], g_w[2], g_w[3], exp_w[f]);
      end
      n_cmp++;
      if (at_target !== exp_at[f]) begin
        n_err++; $display("FAIL slew_at_target%0d: %h, required %h", f, at_target, exp_at[f]);
      end
    end
  endtask

  task automatic test_no_limit;
    int exp_w[4] = '{26, 10, 10, 40};
    wait_cnt(0);
    wr(1'b1, 4'b0010, 16'h0000);
    for (int f = 0; f < 4; f++) begin
      if (f == 2) begin
        wait_cnt(50);
        wr(1'b1, 4'b0010, 16'h00F0);
      end
      meas(-1, 4'hF);
      n_cmp++;
      if (g_w0[1] != exp_w[f] || g_w0[0] != 26) begin
        n_err++; $display("FAIL nolimit_frame%0d: ch1=%0d ch0=%0d, required %0d 26", f, g_w0[1], g_w0[0], exp_w[f]);
      end
    end
  endtask

  task automatic test_enable;
    meas(4, 4'b1011);
    n_cmp++;
    if (g_w[2] != 26 || g_ok[2] !== 1'b1 || g_w[0] != 40) begin
      n_err++; $display("FAIL enable_drop_current: ch2=%0d contig=%b ch0=%0d, required 26 1 40", g_w[2], g_ok[2], g_w[0]);
    end
    meas(-1, 4'b1011);
    n_cmp++;
    if (g_w[2] != 0 || g_w[1] != 26) begin
      n_err++; $display("FAIL enable_drop_next: ch2=%0d ch1=%0d, required 0 26", g_w[2], g_w[1]);
    end
    meas(49, 4'hF);
    n_cmp++;
    if (g_w[2] != 0) begin
      n_err++; $display("FAIL enable_midframe: ch2=%0d, required 0", g_w[2]);
    end
    meas(-1, 4'hF);
    n_cmp++;
    if (g_w[2] != 26 || g_ok[2] !== 1'b1) begin
      n_err++; $display("FAIL enable_restore: ch2=%0d contig=%b, required 26 1", g_w[2], g_ok[2]);
    end
  endtask

  task automatic test_collision;
    int exp_w[4] = '{26, 30, 34, 34};
    wait_cnt(4);
    wr(1'b0, 4'b1000, 16'hC000);
    for (int f = 0; f < 4; f++) begin
      meas(-1, 4'hF);
      n_cmp++;
      if (g_w[3] != exp_w[f]) begin
        n_err++; $display("FAIL collision_frame%0d: ch3=%0d, required %0d", f, g_w[3], exp_w[f]);
      end
    end
    wait_cnt(0);
    wr(1'b0, 4'hF, {4'd11, 4'd6, 4'd10, 4'd14});
    meas(-1, 4'hF);
    n_cmp++;
    if (g_w[0] != 40 || g_w[1] != 26 || g_w[2] != 26 || g_w[3] != 34) begin
      n_err++; $display("FAIL multi_write_old: %0d %0d %0d %0d, required 40 26 26 34", g_w[0], g_w[1], g_w[2], g_w[3]);
    end
    meas(-1, 4'hF);
    n_cmp++;
    if (g_w[0] != 38 || g_w[1] != 30 || g_w[2] != 22 || g_w[3] != 32) begin
      n_err++; $display("FAIL multi_write_new: %0d %0d %0d %0d, required 38 30 22 32", g_w[0], g_w[1], g_w[2], g_w[3]);
    end
  endtask

  task automatic test_reset_mid;
    wait_cnt(10);
    n_cmp++;
    if (pwm !== 4'hF) begin
      n_err++; $display("FAIL reset_mid_pre: pwm=%h, required F", pwm);
    end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (pwm !== 4'h0 || pwm0 !== 4'h0 || frame_start !== 1'b0) begin
      n_err++; $display("FAIL reset_mid_pwm: pwm=%h pwm0=%h fs=%b, required 0 0 0", pwm, pwm0, frame_start);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    meas(-1, 4'hF);
    n_cmp++;
    if (g_w[0] + g_w[1] + g_w[2] + g_w[3] != 0 || g_fs != 1 || g_fs_first !== 1'b1) begin
      n_err++; $display("FAIL reset_mid_frame0: sum=%0d fs=%0d, required 0 1", g_w[0] + g_w[1] + g_w[2] + g_w[3], g_fs);
    end
    meas(-1, 4'hF);
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (g_w[k] != 26 || g_w0[k] != 26) begin
        n_err++; $display("FAIL reset_mid_frame1 ch%0d: %0d/%0d, required 26/26", k, g_w[k], g_w0[k]);
      end
    end
    n_cmp++;
    if (at_target !== 4'hF || at_target0 !== 4'hF) begin
      n_err++; $display("FAIL reset_mid_at_target: %h/%h, required F/F", at_target, at_target0);
    end
  endtask

  initial begin
    test_reset;
    test_slew;
    test_no_limit;
    test_enable;
    test_collision;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
